sharpen_row_stream: RTL
=======================

Name: sharpen_row_stream

Overview:
- Streaming 1-D horizontal sharpening stage for the DLX image-sharpening extension.
- Accepts 32-bit words of four packed 8-bit pixels from the memory-side feeder over a valid/ready handshake.
- Applies per pixel: out = GAIN*c - left - right. Clamps each lane to [0, clamp byte].
- The clamp word comes from the constant generator (all-ones, 32'hFFFFFFFF, gives a ceiling of 0xFF). Results go downstream to the writeback buffer.

Parameters:
- LINE_WORDS, 16, words per image line; legal range >= 2.
- GAIN, 3, centre-pixel multiplier; legal range 1..7.
- CNT_W, 8, column counter width; must satisfy 2^CNT_W >= LINE_WORDS.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear of line state; wins over all other inputs.
- clamp_mask  in  32  per-lane saturation ceiling (byte i caps lane i); normally tied to the all-ones constant.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid && in_ready.
- in_data  in  32  four pixels; lane 0 = [7:0] = leftmost pixel.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream can take the output.
- out_data  out  32  sharpened pixels, same lane order.
- out_last  out  1  marks the final word of a line.

Behaviour:
- Reset (rst_n=0, async): out_valid=0, out_data=0, out_last=0, state=EMPTY, col=0, cur=0, prev_px=0. in_ready is 0 during reset and 1 after reset releases.
- Internal registers:
  - cur: the word awaiting its right neighbour.
  - prev_px: the pixel left of cur lane 0.
  - col: column of the next input word.
- States:
  - EMPTY: no word held.
  - HOLD: cur is held and waiting for the next word.
  - FLUSH: the last word of the line is held; its right edge is replicated.
- Output register is free when !out_valid || out_ready.
- in_ready = (state != FLUSH) && output register free.
- Accept in EMPTY (col==0):
  - cur <= in_data; prev_px <= in_data[7:0] (left-edge replicate); col <= 1; next state HOLD.
- Accept in HOLD:
  - out_data <= F(prev_px, cur, in_data[7:0]); out_valid <= 1; out_last <= 0.
  - prev_px <= cur[31:24]; cur <= in_data.
  - If col == LINE_WORDS-1: col <= 0, next state FLUSH. Otherwise col <= col+1, stay in HOLD.
- FLUSH, when the output register is free:
  - out_data <= F(prev_px, cur, cur[31:24]) (right-edge replicate); out_valid <= 1; out_last <= 1; next state EMPTY.
- Neighbour chain for F:
  - Lane i takes its neighbours from lanes i-1 and i+1.
  - Lane 0's left neighbour is prev_px; lane 3's right neighbour is the supplied next pixel.
- Arithmetic, per lane:
  - s = GAIN*c - l - r, signed 12-bit; no overflow for GAIN <= 7.
  - If s < 0, result = 0.
  - Else if s > clamp byte, result = clamp byte.
  - Else result = s[7:0].
- out_valid drops when out_ready=1 and no new word is produced that cycle.
- Back-to-back throughput: one word per cycle in HOLD. FLUSH costs one extra cycle per line, with in_ready=0 during it.
- Latency: word k of a line appears on the cycle after word k+1 is accepted. The last word appears the cycle after the FLUSH state is entered, if out_ready allows.
- Hold rules: out_data and out_last stay stable while out_valid && !out_ready. in_valid without in_ready has no effect.
- clr=1: state=EMPTY, col=0, out_valid=0, out_last=0. Any partially processed line is discarded, and clr overrides a simultaneous handshake. clamp_mask is sampled combinationally at the cycle F is registered.
- Async reset mid-line: same effect as clr, taken immediately.

Decomposition:
- Shared package sharpen_pkg holds:
  - PIX_W=8, LANES=4, WORD_W=32.
  - The state enum {EMPTY, HOLD, FLUSH}.
  - A function clamp_pix(s, ceiling).
- One sub-module is natural: sharpen_lane, a combinational single-pixel GAIN*c-l-r computation with clamp.
- sharpen_row_stream instantiates sharpen_lane four times inside its F computation.

Test Plan:
- Flat line, LINE_WORDS=2, clamp all-ones: in 0x40404040, 0x40404040 -> out 0x40404040 (last=0) then 0x40404040 (last=1).
- Ramp with edges: in 0x04030201, 0x08070605 -> out 0x04030200 then 0x09070605 with out_last=1.
- Saturation:
  - in 0x00FF0000, 0x00000000 with mask 0xFFFFFFFF -> word0 = 0x00FF0000 (lane 2 = 765 -> 0xFF; lanes 1 and 3 = -255 -> 0).
  - Same input with mask 0x7F7F7F7F -> word0 = 0x007F0000.
- Backpressure: hold out_ready=0 for 3 cycles with output pending -> out_data/out_last stable, in_ready=0. Releasing out_ready resumes with no lost or duplicated words.
- Clear mid-line: LINE_WORDS=4, accept 2 words, assert clr -> out_valid=0, state EMPTY. The next word is treated as col 0 (left edge replicated).
- Async reset during FLUSH: rst_n low -> out_valid=0 immediately; after release, in_ready=1 and a fresh line processes correctly.

Source files
------------

// File: rtl/sharpen_pkg.sv
// Shared definitions for the horizontal sharpening stream: pixel geometry,
// the line-state encoding and the per-lane saturation helper.
package sharpen_pkg;

  localparam int PIX_W  = 8;
  localparam int LANES  = 4;
  localparam int WORD_W = 32;

  // GAIN*c - l - r spans -510 .. 1785 for GAIN <= 7, which fits 12 signed bits.
  localparam int SUM_W = 12;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // no word held
    HOLD  = 2'd1,  // cur held, waiting for its right neighbour
    FLUSH = 2'd2   // last word of the line held, right edge replicated
  } state_t;

  // Saturate a signed lane sum into [0, ceiling].
  function automatic logic [PIX_W-1:0] clamp_pix(
    input logic signed [SUM_W-1:0] s,
    input logic [PIX_W-1:0]        ceiling
  );
    logic [PIX_W-1:0]        r;
    logic signed [SUM_W-1:0] ceil_ext;
    ceil_ext = $signed({{(SUM_W-PIX_W){1'b0}}, ceiling});
    if (s < 0) begin
      r = '0;
    end else if (s > ceil_ext) begin
      r = ceiling;
    end else begin
      r = s[PIX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sharpen_lane.sv
// One pixel of the sharpening kernel: GAIN*centre - left - right, clamped
// to [0, ceiling]. Purely combinational.
module sharpen_lane
  import sharpen_pkg::*;
#(
  parameter int GAIN = 3
) (
  input  logic [PIX_W-1:0] left_px,
  input  logic [PIX_W-1:0] centre_px,
  input  logic [PIX_W-1:0] right_px,
  input  logic [PIX_W-1:0] ceiling,
  output logic [PIX_W-1:0] result
);

  logic signed [SUM_W-1:0] gain_ext;
  logic signed [SUM_W-1:0] c_ext;
  logic signed [SUM_W-1:0] l_ext;
  logic signed [SUM_W-1:0] r_ext;
  logic signed [SUM_W-1:0] sum;

  assign gain_ext = SUM_W'(GAIN);
  assign c_ext    = $signed({{(SUM_W-PIX_W){1'b0}}, centre_px});
  assign l_ext    = $signed({{(SUM_W-PIX_W){1'b0}}, left_px});
  assign r_ext    = $signed({{(SUM_W-PIX_W){1'b0}}, right_px});

  // Kernel sum then saturation into the lane ceiling.
  always_comb begin
    sum    = gain_ext * c_ext - l_ext - r_ext;
    result = clamp_pix(sum, ceiling);
  end

endmodule

// File: rtl/sharpen_row_stream.sv
// Streaming 1-D horizontal sharpening stage. Each 32-bit input word carries
// four pixels (lane 0 = leftmost). A word is emitted once its right
// neighbour arrives; the last word of a line is emitted from FLUSH with its
// right edge replicated, and the first word of a line replicates its left
// edge.
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are high. A producer holding valid keeps its data stable
// until that edge; valid without ready has no effect.
module sharpen_row_stream
  import sharpen_pkg::*;
#(
  parameter int LINE_WORDS = 16,
  parameter int GAIN       = 3,
  parameter int CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic [WORD_W-1:0]   clamp_mask,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   out_data,
  output logic                out_last,
  output logic [1:0]          state_dbg
);

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   col_q;
  logic [CNT_W-1:0]   col_d;
  logic [WORD_W-1:0]  cur_q;
  logic [PIX_W-1:0]   prev_px_q;

  logic               out_free;
  logic               accept;
  logic               load_first;
  logic               shift;
  logic               emit;
  logic               emit_last;
  logic [PIX_W-1:0]   next_px;
  logic [WORD_W-1:0]  f_word;

  // The output register can take a new word when empty or being drained.
  assign out_free  = !out_valid || out_ready;
  // Gated by rst_n so nothing is offered to the feeder while in reset.
  assign in_ready  = rst_n && (state_q != FLUSH) && out_free;
  assign accept    = in_valid && in_ready;
  assign state_dbg = state_q;

  // F(prev_px, cur, next_px): four kernel lanes with a neighbour chain that
  // crosses lane boundaries inside the word and borrows prev_px / next_px
  // at the ends.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [PIX_W-1:0] left_px;
    logic [PIX_W-1:0] right_px;
    logic [PIX_W-1:0] lane_res;

    if (i == 0) begin : g_left_edge
      assign left_px = prev_px_q;
    end else begin : g_left_in
      assign left_px = cur_q[PIX_W*(i-1) +: PIX_W];
    end

    if (i == LANES-1) begin : g_right_edge
      assign right_px = next_px;
    end else begin : g_right_in
      assign right_px = cur_q[PIX_W*(i+1) +: PIX_W];
    end

    sharpen_lane #(
      .GAIN (GAIN)
    ) u_lane (
      .left_px   (left_px),
      .centre_px (cur_q[PIX_W*i +: PIX_W]),
      .right_px  (right_px),
      .ceiling   (clamp_mask[PIX_W*i +: PIX_W]),
      .result    (lane_res)
    );

    assign f_word[PIX_W*i +: PIX_W] = lane_res;
  end

  // Next-state, column and datapath-control decode.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    load_first = 1'b0;
    shift      = 1'b0;
    emit       = 1'b0;
    emit_last  = 1'b0;
    next_px    = in_data[PIX_W-1:0];
    case (state_q)
      EMPTY: begin
        if (accept) begin
          load_first = 1'b1;
          col_d      = CNT_W'(1);
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (accept) begin
          emit  = 1'b1;
          shift = 1'b1;
          if (col_q == CNT_W'(LINE_WORDS-1)) begin
            col_d   = '0;
            state_d = FLUSH;
          end else begin
            col_d = col_q + CNT_W'(1);
          end
        end
      end
      FLUSH: begin
        next_px = cur_q[WORD_W-1 -: PIX_W];
        if (out_free) begin
          emit      = 1'b1;
          emit_last = 1'b1;
          state_d   = EMPTY;
        end
      end
      default: begin
        state_d = EMPTY;
        col_d   = '0;
      end
    endcase
  end

  // Line state: FSM, column counter, held word and its left neighbour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      col_q     <= '0;
      cur_q     <= '0;
      prev_px_q <= '0;
    end else if (clr) begin
      state_q <= EMPTY;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      if (load_first) begin
        cur_q     <= in_data;
        prev_px_q <= in_data[PIX_W-1:0];
      end else if (shift) begin
        prev_px_q <= cur_q[WORD_W-1 -: PIX_W];
        cur_q     <= in_data;
      end
    end
  end

  // Output register: load on emit, drop valid once drained, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_data  <= f_word;
      out_last  <= emit_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
